// File: rtl/s1_unidade_controle.sv
// Moore control unit for the memory game: shows a growing sequence, checks plays, scores, ends the game.
// Optional macro S1_UC_TIMEOUT_EN enables the play-timeout path (contaT and FIM_TIMEOUT).
module s1_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       sel_nivel,
    input  logic       sel_memoria,
    input  logic       enderecoIgualLimite,
    input  logic       botoesIgualMemoria,
    input  logic       fimL,
    input  logic       jogadafeita,
    input  logic       timeout,
    input  logic       muda_leds,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraT2,
    output logic       contaT2,
    output logic       mostraJ,
    output logic       mostraB,
    output logic       zeraErro,
    output logic       contaErro,
    output logic       regErro,
    output logic       zeraPontos,
    output logic       regPontos,
    output logic       nivel,
    output logic       memoria,
    output logic       pronto,
    output logic       acertou,
    output logic [4:0] db_estado
);

`ifdef S1_UC_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    typedef enum logic [4:0] {
        INICIAL       = 5'h00,
        PREPARA       = 5'h01,
        INICIO_RODADA = 5'h02,
        MOSTRA        = 5'h03,
        APAGA         = 5'h04,
        PROX_MOSTRA   = 5'h05,
        FIM_MOSTRA    = 5'h06,
        ESPERA        = 5'h07,
        REGISTRA      = 5'h08,
        COMPARA       = 5'h09,
        PROX_JOGADA   = 5'h0A,
        ERROU         = 5'h0B,
        FIM_RODADA    = 5'h0C,
        PROX_RODADA   = 5'h0D,
        PONT_INICIO   = 5'h0E,
        PONT_LE       = 5'h0F,
        PONT_ACUM     = 5'h10,
        PONT_PROX     = 5'h11,
        FIM_ACERTO    = 5'h12,
        FIM_TIMEOUT   = 5'h13,
        FIM_ERROS     = 5'h14
    } state_t;

    typedef struct packed {
        logic zeraR;
        logic registraR;
        logic zeraL;
        logic contaL;
        logic zeraE;
        logic contaE;
        logic zeraT;
        logic contaT;
        logic zeraT2;
        logic contaT2;
        logic mostraJ;
        logic mostraB;
        logic zeraErro;
        logic contaErro;
        logic regErro;
        logic zeraPontos;
        logic regPontos;
        logic pronto;
        logic acertou;
    } ctl_t;

    state_t     state_q, state_d;
    ctl_t       ctl_q, ctl_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic       nivel_q, nivel_d;
    logic       memoria_q, memoria_d;

    // Outputs are decoded from the next state and registered, so they are
    // glitch-free flop outputs that still line up with the current state.
    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            PREPARA: begin
                c.zeraL = 1'b1; c.zeraE = 1'b1; c.zeraR = 1'b1; c.zeraErro = 1'b1;
                c.zeraPontos = 1'b1; c.zeraT = 1'b1; c.zeraT2 = 1'b1;
            end
            INICIO_RODADA: begin c.zeraE = 1'b1; c.zeraT2 = 1'b1; end
            MOSTRA:        begin c.mostraJ = 1'b1; c.contaT2 = 1'b1; end
            APAGA:         c.contaT2 = 1'b1;
            PROX_MOSTRA:   begin c.contaE = 1'b1; c.zeraT2 = 1'b1; end
            FIM_MOSTRA:    begin c.zeraE = 1'b1; c.zeraT = 1'b1; c.zeraR = 1'b1; end
            ESPERA:        begin c.mostraB = 1'b1; c.contaT = TMO_EN; end
            REGISTRA:      begin c.registraR = 1'b1; c.mostraB = 1'b1; end
            PROX_JOGADA:   begin c.contaE = 1'b1; c.zeraT = 1'b1; end
            ERROU:         c.contaErro = 1'b1;
            FIM_RODADA:    c.regErro = 1'b1;
            PROX_RODADA:   begin c.contaL = 1'b1; c.zeraErro = 1'b1; end
            PONT_INICIO:   c.zeraL = 1'b1;
            PONT_ACUM:     c.regPontos = 1'b1;
            PONT_PROX:     c.contaL = 1'b1;
            FIM_ACERTO:    begin c.pronto = 1'b1; c.acertou = 1'b1; end
            FIM_TIMEOUT:   c.pronto = TMO_EN;
            FIM_ERROS:     c.pronto = 1'b1;
            default:       c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = INICIAL;
        case (state_q)
            INICIAL:       state_d = iniciar ? PREPARA : INICIAL;
            PREPARA:       state_d = INICIO_RODADA;
            INICIO_RODADA: state_d = MOSTRA;
            MOSTRA:        state_d = muda_leds ? APAGA : MOSTRA;
            APAGA: begin
                if (!muda_leds)               state_d = APAGA;
                else if (enderecoIgualLimite) state_d = FIM_MOSTRA;
                else                          state_d = PROX_MOSTRA;
            end
            PROX_MOSTRA:   state_d = MOSTRA;
            FIM_MOSTRA:    state_d = ESPERA;
            ESPERA: begin
                if (jogadafeita)             state_d = REGISTRA;
                else if (timeout && TMO_EN)  state_d = FIM_TIMEOUT;
                else                         state_d = ESPERA;
            end
            REGISTRA:      state_d = COMPARA;
            COMPARA: begin
                if (!botoesIgualMemoria)      state_d = ERROU;
                else if (enderecoIgualLimite) state_d = FIM_RODADA;
                else                          state_d = PROX_JOGADA;
            end
            PROX_JOGADA:   state_d = ESPERA;
            ERROU:         state_d = (err_cnt_q >= 4'd14) ? FIM_ERROS : INICIO_RODADA;
            FIM_RODADA:    state_d = fimL ? PONT_INICIO : PROX_RODADA;
            PROX_RODADA:   state_d = INICIO_RODADA;
            PONT_INICIO:   state_d = PONT_LE;
            PONT_LE:       state_d = PONT_ACUM;
            PONT_ACUM:     state_d = fimL ? FIM_ACERTO : PONT_PROX;
            PONT_PROX:     state_d = PONT_LE;
            FIM_ACERTO:    state_d = iniciar ? PREPARA : FIM_ACERTO;
            FIM_TIMEOUT:   state_d = !TMO_EN ? INICIAL : (iniciar ? PREPARA : FIM_TIMEOUT);
            FIM_ERROS:     state_d = iniciar ? PREPARA : FIM_ERROS;
            default:       state_d = INICIAL;
        endcase
    end

    // Error counter saturates at 15; it is cleared on a new game or a new round.
    always_comb begin
        err_cnt_d = err_cnt_q;
        nivel_d   = nivel_q;
        memoria_d = memoria_q;
        if (state_q == PREPARA || state_q == PROX_RODADA) begin
            err_cnt_d = 4'd0;
        end else if (state_q == ERROU && err_cnt_q != 4'hF) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
        if (state_q == PREPARA) begin
            nivel_d   = sel_nivel;
            memoria_d = sel_memoria;
        end
        ctl_d = decode(state_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= INICIAL;
            ctl_q     <= '0;
            err_cnt_q <= 4'd0;
            nivel_q   <= 1'b0;
            memoria_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            err_cnt_q <= err_cnt_d;
            nivel_q   <= nivel_d;
            memoria_q <= memoria_d;
        end
    end

    assign zeraR      = ctl_q.zeraR;
    assign registraR  = ctl_q.registraR;
    assign zeraL      = ctl_q.zeraL;
    assign contaL     = ctl_q.contaL;
    assign zeraE      = ctl_q.zeraE;
    assign contaE     = ctl_q.contaE;
    assign zeraT      = ctl_q.zeraT;
    assign contaT     = ctl_q.contaT;
    assign zeraT2     = ctl_q.zeraT2;
    assign contaT2    = ctl_q.contaT2;
    assign mostraJ    = ctl_q.mostraJ;
    assign mostraB    = ctl_q.mostraB;
    assign zeraErro   = ctl_q.zeraErro;
    assign contaErro  = ctl_q.contaErro;
    assign regErro    = ctl_q.regErro;
    assign zeraPontos = ctl_q.zeraPontos;
    assign regPontos  = ctl_q.regPontos;
    assign pronto     = ctl_q.pronto;
    assign acertou    = ctl_q.acertou;
    assign nivel      = nivel_q;
    assign memoria    = memoria_q;
    assign db_estado  = state_q;

endmodule

// File: tb/tb_s1_unidade_controle.sv
// Directed bench for s1_unidade_controle: reset, full won game, error path, timeout behaviour.
module tb_s1_unidade_controle;

    logic clock, reset, iniciar, sel_nivel, sel_memoria;
    logic enderecoIgualLimite, botoesIgualMemoria, fimL, jogadafeita, timeout, muda_leds;
    logic zeraR, registraR, zeraL, contaL, zeraE, contaE, zeraT, contaT, zeraT2, contaT2;
    logic mostraJ, mostraB, zeraErro, contaErro, regErro, zeraPontos, regPontos;
    logic nivel, memoria, pronto, acertou;
    logic [4:0] db_estado;
    logic [20:0] all_out;

    int checks = 0;
    int errors = 0;
    int n_fim_rodada = 0;
    int n_reg_pontos = 0;
    int fr0, rp0;

    s1_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .sel_nivel(sel_nivel),
        .sel_memoria(sel_memoria), .enderecoIgualLimite(enderecoIgualLimite),
        .botoesIgualMemoria(botoesIgualMemoria), .fimL(fimL), .jogadafeita(jogadafeita),
        .timeout(timeout), .muda_leds(muda_leds),
        .zeraR(zeraR), .registraR(registraR), .zeraL(zeraL), .contaL(contaL),
        .zeraE(zeraE), .contaE(contaE), .zeraT(zeraT), .contaT(contaT),
        .zeraT2(zeraT2), .contaT2(contaT2), .mostraJ(mostraJ), .mostraB(mostraB),
        .zeraErro(zeraErro), .contaErro(contaErro), .regErro(regErro),
        .zeraPontos(zeraPontos), .regPontos(regPontos), .nivel(nivel), .memoria(memoria),
        .pronto(pronto), .acertou(acertou), .db_estado(db_estado)
    );

    assign all_out = {zeraR, registraR, zeraL, contaL, zeraE, contaE, zeraT, contaT,
                      zeraT2, contaT2, mostraJ, mostraB, zeraErro, contaErro, regErro,
                      zeraPontos, regPontos, nivel, memoria, pronto, acertou};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (db_estado == 5'h0C) n_fim_rodada++;
        if (regPontos) n_reg_pontos++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog sim_time obs=expired exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Enter at INICIO_RODADA, show n items, leave in ESPERA.
    task automatic mostra(input int n);
        muda_leds = 1'b0;
        step();
        chk("st_mostra", db_estado, 5'h03);
        chk("mostraJ_on", mostraJ, 1'b1);
        for (int i = 0; i < n; i++) begin
            muda_leds = 1'b1;
            enderecoIgualLimite = (i == n - 1);
            step();
            chk("st_apaga", db_estado, 5'h04);
            chk("mostraJ_off", mostraJ, 1'b0);
            step();
            if (i == n - 1) begin
                chk("st_fim_mostra", db_estado, 5'h06);
                chk("zeraR_fm", zeraR, 1'b1);
            end else begin
                chk("st_prox_mostra", db_estado, 5'h05);
                chk("contaE_pm", contaE, 1'b1);
                step();
                chk("st_mostra_n", db_estado, 5'h03);
            end
        end
        muda_leds = 1'b0;
        enderecoIgualLimite = 1'b0;
        step();
        chk("st_espera", db_estado, 5'h07);
        chk("mostraB_esp", mostraB, 1'b1);
    endtask

    // Enter at ESPERA; one play.
    task automatic joga(input logic ok, input logic last);
        logic [4:0] exp_st;
        jogadafeita = 1'b1;
        step();
        chk("st_registra", db_estado, 5'h08);
        chk("registraR", registraR, 1'b1);
        jogadafeita = 1'b0;
        botoesIgualMemoria = ok;
        enderecoIgualLimite = last;
        step();
        chk("st_compara", db_estado, 5'h09);
        chk("registraR_off", registraR, 1'b0);
        step();
        exp_st = !ok ? 5'h0B : (last ? 5'h0C : 5'h0A);
        chk("st_after_cmp", db_estado, exp_st);
        if (ok && !last) begin
            chk("contaE_pj", contaE, 1'b1);
            enderecoIgualLimite = 1'b0;
            step();
            chk("st_espera_pj", db_estado, 5'h07);
        end
        botoesIgualMemoria = 1'b1;
        enderecoIgualLimite = 1'b0;
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; sel_nivel = 1'b0; sel_memoria = 1'b0;
        enderecoIgualLimite = 1'b0; botoesIgualMemoria = 1'b1; fimL = 1'b0;
        jogadafeita = 1'b0; timeout = 1'b0; muda_leds = 1'b0;
        #3;
        chk("rst_state", db_estado, 5'h00);
        chk("rst_outs", all_out, 21'd0);
        #9 reset = 1'b1;
        step();
        chk("idle_stay", db_estado, 5'h00);

        // Start, capture selections, iniciar held high must be ignored afterwards
        iniciar = 1'b1; sel_nivel = 1'b1; sel_memoria = 1'b1;
        step();
        chk("st_prepara", db_estado, 5'h01);
        chk("zeraPontos_prep", zeraPontos, 1'b1);
        chk("zeraT2_prep", zeraT2, 1'b1);
        chk("pronto_prep", pronto, 1'b0);
        step();
        chk("st_inicio_rodada", db_estado, 5'h02);
        chk("nivel_cap", nivel, 1'b1);
        chk("memoria_cap", memoria, 1'b1);
        chk("zeraE_ir", zeraE, 1'b1);
        step();
        chk("st_mostra0", db_estado, 5'h03);
        step();
        chk("mostra_hold", db_estado, 5'h03);

        // Asynchronous reset mid-MOSTRA
        reset = 1'b0;
        #1;
        chk("async_rst_state", db_estado, 5'h00);
        chk("async_rst_outs", all_out, 21'd0);
        iniciar = 1'b0;
        #2 reset = 1'b1;
        step();
        chk("post_rst_idle", db_estado, 5'h00);

        // Full game at sel_nivel=0: 8 rounds, all plays correct
        fr0 = n_fim_rodada;
        rp0 = n_reg_pontos;
        iniciar = 1'b1; sel_nivel = 1'b0; sel_memoria = 1'b0;
        step();
        chk("g_prepara", db_estado, 5'h01);
        iniciar = 1'b0;
        step();
        chk("g_inicio", db_estado, 5'h02);
        chk("g_nivel0", nivel, 1'b0);
        for (int r = 0; r < 8; r++) begin
            mostra(r + 1);
            for (int j = 0; j <= r; j++) joga(1'b1, (j == r));
            chk("regErro_fr", regErro, 1'b1);
            fimL = (r == 7);
            step();
            if (r < 7) begin
                chk("st_prox_rodada", db_estado, 5'h0D);
                chk("contaL_pr", contaL, 1'b1);
                fimL = 1'b0;
                step();
                chk("st_ir_again", db_estado, 5'h02);
            end else begin
                chk("st_pont_inicio", db_estado, 5'h0E);
                chk("zeraL_pi", zeraL, 1'b1);
            end
        end
        fimL = 1'b0;
        for (int p = 0; p < 8; p++) begin
            step();
            chk("st_pont_le", db_estado, 5'h0F);
            fimL = (p == 7);
            step();
            chk("st_pont_acum", db_estado, 5'h10);
            chk("regPontos_pa", regPontos, 1'b1);
            step();
            fimL = 1'b0;
            if (p < 7) begin
                chk("st_pont_prox", db_estado, 5'h11);
                chk("contaL_pp", contaL, 1'b1);
            end else begin
                chk("st_fim_acerto", db_estado, 5'h12);
                chk("pronto_win", pronto, 1'b1);
                chk("acertou_win", acertou, 1'b1);
            end
        end
        chk("n_fim_rodada", n_fim_rodada - fr0, 8);
        chk("n_regPontos", n_reg_pontos - rp0, 8);
        step();
        chk("fim_acerto_hold", db_estado, 5'h12);
        chk("score_kept", zeraPontos, 1'b0);

        // Error path: 15 wrong plays in round 1
        iniciar = 1'b1;
        step();
        chk("e_prepara", db_estado, 5'h01);
        chk("e_pronto_clr", pronto, 1'b0);
        chk("e_acertou_clr", acertou, 1'b0);
        iniciar = 1'b0;
        step();
        chk("e_inicio", db_estado, 5'h02);
        for (int k = 0; k < 15; k++) begin
            mostra(1);
            joga(1'b0, 1'b1);
            chk("contaErro_on", contaErro, 1'b1);
            chk("contaL_err", contaL, 1'b0);
            step();
            chk("st_after_errou", db_estado, (k == 14) ? 5'h14 : 5'h02);
            chk("contaErro_off", contaErro, 1'b0);
        end
        chk("pronto_erros", pronto, 1'b1);
        chk("acertou_erros", acertou, 1'b0);

        // Timeout handling in ESPERA
        iniciar = 1'b1;
        step();
        chk("t_prepara", db_estado, 5'h01);
        iniciar = 1'b0;
        step();
        mostra(1);
`ifdef S1_UC_TIMEOUT_EN
        chk("contaT_on", contaT, 1'b1);
        timeout = 1'b1;
        step();
        chk("st_fim_timeout", db_estado, 5'h13);
        chk("pronto_tmo", pronto, 1'b1);
        chk("acertou_tmo", acertou, 1'b0);
        timeout = 1'b0;
        iniciar = 1'b1;
        step();
        chk("t_prepara2", db_estado, 5'h01);
        iniciar = 1'b0;
        step();
        mostra(1);
`else
        chk("contaT_off", contaT, 1'b0);
        timeout = 1'b1;
        step();
        chk("tmo_ignored", db_estado, 5'h07);
        chk("contaT_held0", contaT, 1'b0);
        step();
        chk("tmo_ignored2", db_estado, 5'h07);
`endif
        timeout = 1'b1;
        jogadafeita = 1'b1;
        step();
        chk("jogada_wins", db_estado, 5'h08);
        timeout = 1'b0;
        jogadafeita = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/s1_unidade_controle.md
S1_UNIDADE_CONTROLE -- requirements
Module: s1_unidade_controle

Interface
REQ-001 The module SHALL have no parameters; all sizing is fixed by this document.
REQ-002 clock  in  1  single rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 iniciar  in  1  start request, level-sampled in INICIAL and FIM_* states.
REQ-005 sel_nivel, sel_memoria  in  1 each  game length and ROM select, captured in PREPARA.
REQ-006 enderecoIgualLimite, botoesIgualMemoria, fimL, jogadafeita, timeout, muda_leds  in  1 each  datapath condition flags.
REQ-007 zeraR, registraR, zeraL, contaL, zeraE, contaE  out  1 each  register, limit-counter and address-counter controls.
REQ-008 zeraT, contaT, zeraT2, contaT2  out  1 each  5000-cycle timeout and 500-cycle LED-timer controls.
REQ-009 mostraJ, mostraB, zeraErro, contaErro, regErro, zeraPontos, regPontos  out  1 each  display, error and score controls.
REQ-010 nivel, memoria  out  1 each  registered copies of sel_nivel and sel_memoria.
REQ-011 pronto, acertou  out  1 each  game over; game won.
REQ-012 db_estado  out  5  current state code.

Function
REQ-013 Moore FSM SHALL use codes: 00 INICIAL, 01 PREPARA, 02 INICIO_RODADA, 03 MOSTRA, 04 APAGA, 05 PROX_MOSTRA, 06 FIM_MOSTRA, 07 ESPERA, 08 REGISTRA, 09 COMPARA, 0A PROX_JOGADA, 0B ERROU, 0C FIM_RODADA, 0D PROX_RODADA, 0E PONT_INICIO, 0F PONT_LE, 10 PONT_ACUM, 11 PONT_PROX, 12 FIM_ACERTO, 13 FIM_TIMEOUT, 14 FIM_ERROS; unused codes SHALL go to INICIAL.
REQ-014 All outputs SHALL be functions of state only and driven from flops (glitch-free), since zeraR and zeraPontos drive asynchronous clears.
REQ-015 INICIAL: iniciar=1 -> PREPARA; iniciar is ignored in every other non-FIM state.
REQ-016 PREPARA: zeraL, zeraE, zeraR, zeraErro, zeraPontos, zeraT, zeraT2 high; capture nivel/memoria; clear internal err_cnt -> INICIO_RODADA.
REQ-017 INICIO_RODADA: zeraE, zeraT2 -> MOSTRA. MOSTRA: mostraJ, contaT2; muda_leds -> APAGA.
REQ-018 APAGA: contaT2 (LEDs dark); on muda_leds: enderecoIgualLimite -> FIM_MOSTRA, else PROX_MOSTRA (contaE, zeraT2) -> MOSTRA.
REQ-019 FIM_MOSTRA: zeraE, zeraT, zeraR -> ESPERA. ESPERA: mostraB, contaT; jogadafeita -> REGISTRA; else timeout -> FIM_TIMEOUT; jogadafeita wins when simultaneous.
REQ-020 REGISTRA: registraR, mostraB -> COMPARA (exactly one cycle of latency before compare).
REQ-021 COMPARA: !botoesIgualMemoria -> ERROU; else enderecoIgualLimite -> FIM_RODADA; else PROX_JOGADA (contaE, zeraT) -> ESPERA.
REQ-022 ERROU: contaErro, err_cnt+1; if err_cnt was 14 -> FIM_ERROS, else -> INICIO_RODADA (round replayed).
REQ-023 FIM_RODADA: regErro; fimL -> PONT_INICIO, else PROX_RODADA (contaL, zeraErro, err_cnt=0) -> INICIO_RODADA.
REQ-024 Scoring: PONT_INICIO zeraL -> PONT_LE (RAM read cycle) -> PONT_ACUM regPontos; fimL -> FIM_ACERTO, else PONT_PROX contaL -> PONT_LE.
REQ-025 FIM_ACERTO/FIM_TIMEOUT/FIM_ERROS: pronto=1, acertou=1 only in FIM_ACERTO; iniciar -> PREPARA; score not cleared until PREPARA.
REQ-026 err_cnt SHALL be 4 bits, never wrap; 15 errors in one round ends the game.

Reset
REQ-027 reset=0 SHALL immediately force INICIAL, err_cnt=0, nivel=memoria=0 and every output 0, including mid-round or mid-scoring.
REQ-028 First transition SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro S1_UC_TIMEOUT_EN defined: behaviour per REQ-019; undefined: contaT held 0, timeout ignored, FIM_TIMEOUT unreachable (code 13 still decoded to INICIAL).

Verification
REQ-030 Reset low mid-MOSTRA -> db_estado=00, all outputs 0 asynchronously.
REQ-031 iniciar=1, sel_nivel=0, all plays correct -> 8 rounds, 8 FIM_RODADA visits, then 8 regPontos pulses, FIM_ACERTO, pronto=1, acertou=1.
REQ-032 Round 1 wrong play (botoesIgualMemoria=0) -> ERROU, contaErro one cycle, back to 02 with limit unchanged.
REQ-033 15 consecutive wrong plays in one round -> FIM_ERROS (14), acertou=0.
REQ-034 With macro: no play, timeout=1 in ESPERA -> FIM_TIMEOUT (13); same cycle with jogadafeita=1 -> REGISTRA (08).
REQ-035 Without macro: timeout=1 held in ESPERA -> remains 07, contaT=0.
